// File: rtl/prc_frame_copy.sv
// prc_frame_copy: bus initiator that copies the 96x64 1bpp framebuffer from RAM to the LCD controller.
// Optional feature: define PRC_FRAME_COPY_ABORT_EN to let 'abort' cancel a copy in progress.
module prc_frame_copy #(
    parameter logic [23:0] FB_BASE       = 24'h001000,
    parameter logic [23:0] LCD_CMD_ADDR  = 24'h0020FE,
    parameter logic [23:0] LCD_DATA_ADDR = 24'h0020FF,
    parameter int          NUM_PAGES     = 8,
    parameter int          NUM_COLS      = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [23:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_count
);

    localparam int PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_PAGE,
        S_CMD_COLH,
        S_CMD_COLL,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [PAGE_W-1:0] r_page;
    logic [COL_W-1:0]  r_col;
    logic [7:0]        r_data;
    logic [7:0]        r_frameCount;
    logic [23:0]       w_rdAddress;
    logic              w_abort;

`ifdef PRC_FRAME_COPY_ABORT_EN
    // FIN is left alone: that frame has already completed and is signalling done.
    assign w_abort = abort && (r_state != S_FIN);
`else
    logic w_unusedAbort;
    assign w_unusedAbort = abort;
    assign w_abort       = 1'b0;
`endif

    assign w_rdAddress = FB_BASE + 24'(r_page) * 24'(NUM_COLS) + 24'(r_col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_page       <= '0;
            r_col        <= '0;
            r_data       <= '0;
            r_frameCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE) begin
                r_page <= '0;
                r_col  <= '0;
            end
            if (r_state == S_RD && bus_grant) begin
                r_data <= bus_data_in;
            end
            // Column/page walk advances only on a granted data write.
            if (r_state == S_WR && bus_grant) begin
                if (r_col != LAST_COL) begin
                    r_col <= r_col + COL_W'(1);
                end else if (r_page != LAST_PAGE) begin
                    r_col  <= '0;
                    r_page <= r_page + PAGE_W'(1);
                end
            end
            if (r_state == S_FIN) begin
                r_frameCount <= r_frameCount + 8'd1;
            end
        end
    end

    always_comb begin
        w_nextState  = r_state;
        bus_address  = '0;
        bus_data_out = '0;
        bus_read     = 1'b0;
        bus_write    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_nextState = S_CMD_PAGE;
            end
            S_CMD_PAGE: begin
                bus_address  = LCD_CMD_ADDR;
                bus_data_out = 8'hB0 | 8'(r_page);
                bus_write    = bus_grant;
                if (bus_grant) w_nextState = S_CMD_COLH;
            end
            S_CMD_COLH: begin
                bus_address  = LCD_CMD_ADDR;
                bus_data_out = 8'h10;
                bus_write    = bus_grant;
                if (bus_grant) w_nextState = S_CMD_COLL;
            end
            S_CMD_COLL: begin
                bus_address  = LCD_CMD_ADDR;
                bus_data_out = 8'h00;
                bus_write    = bus_grant;
                if (bus_grant) w_nextState = S_RD;
            end
            S_RD: begin
                bus_address = w_rdAddress;
                bus_read    = bus_grant;
                if (bus_grant) w_nextState = S_WR;
            end
            S_WR: begin
                bus_address  = LCD_DATA_ADDR;
                bus_data_out = r_data;
                bus_write    = bus_grant;
                if (bus_grant) begin
                    if (r_col != LAST_COL)       w_nextState = S_RD;
                    else if (r_page != LAST_PAGE) w_nextState = S_CMD_PAGE;
                    else                         w_nextState = S_FIN;
                end
            end
            S_FIN: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (w_abort) w_nextState = S_IDLE;
    end

    assign busy        = (r_state != S_IDLE) && (r_state != S_FIN);
    assign bus_req     = busy;
    assign done        = (r_state == S_FIN);
    assign frame_count = r_frameCount;

endmodule

// File: tb/tb_prc_frame_copy.sv
// tb_prc_frame_copy: drives randomized grant patterns and RAM contents into prc_frame_copy and
// checks every bus access, the busy/done timing and frame_count against a frame-level model.
module tb_prc_frame_copy;

    localparam logic [23:0] FB       = 24'h001000;
    localparam logic [23:0] CMD      = 24'h0020FE;
    localparam logic [23:0] DAT      = 24'h0020FF;
    localparam int          PAGES    = 8;
    localparam int          COLS     = 96;
    localparam int          FRAME    = PAGES * COLS;
    localparam int          ACCESSES = PAGES * (3 + 2 * COLS);
    localparam int          MAXC     = 8000;
`ifdef PRC_FRAME_COPY_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        bus_req;
    logic        bus_grant;
    logic [23:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        busy;
    logic        done;
    logic [7:0]  frame_count;

    logic [7:0]  ram [0:FRAME-1];
    bit          grantSeq [0:MAXC-1];
    logic [23:0] ramOffset;
    int          vectors     = 0;
    int          miscompares = 0;
    int          expFrames   = 0;

    prc_frame_copy dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .bus_req      (bus_req),
        .bus_grant    (bus_grant),
        .bus_address  (bus_address),
        .bus_read     (bus_read),
        .bus_write    (bus_write),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .busy         (busy),
        .done         (done),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    // RAM model answers combinationally for any address inside the framebuffer.
    assign ramOffset   = bus_address - FB;
    assign bus_data_in = (ramOffset < 24'(FRAME)) ? ram[ramOffset[9:0]] : 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One copy: grantMode 0 = always granted, 1 = every other cycle, 2 = random.
    task automatic applyStimulus(input int grantMode, input int midStart, input bit startInFin,
                                 input bit abortTrig, input bit resetTrig);
        int          expDone;
        int          granted;
        int          cyc;
        int          doneCnt;
        int          doneAt;
        int          rdIdx;
        int          abortCyc;
        int          endCyc;
        bit          stopped;
        bit          abortFired;
        bit          resetFired;
        bit          cancelled;
        bit          expBusy;
        logic [31:0] expWr [$];
        logic [31:0] lastWr;
        logic [31:0] expEntry;

        for (int c = 0; c < MAXC; c++) begin
            if (grantMode == 0)      grantSeq[c] = 1'b1;
            else if (grantMode == 1) grantSeq[c] = c[0];
            else                     grantSeq[c] = ($urandom_range(0, 3) != 0);
        end
        // Every access needs exactly one granted cycle; done follows the last one.
        granted = 0;
        expDone = MAXC;
        for (int c = 1; c < MAXC; c++) begin
            if (grantSeq[c]) granted++;
            if (granted == ACCESSES) begin
                expDone = c + 1;
                break;
            end
        end
        for (int p = 0; p < PAGES; p++) begin
            expWr.push_back({CMD, 8'hB0 | 8'(p)});
            expWr.push_back({CMD, 8'h10});
            expWr.push_back({CMD, 8'h00});
            for (int c = 0; c < COLS; c++) expWr.push_back({DAT, ram[p * COLS + c]});
        end

        doneCnt    = 0;
        doneAt     = -1;
        rdIdx      = 0;
        abortCyc   = 0;
        stopped    = 1'b0;
        abortFired = 1'b0;
        resetFired = 1'b0;
        lastWr     = '0;

        @(posedge clk);
        #1;
        cyc       = 0;
        start     = 1'b1;
        abort     = 1'b0;
        bus_grant = grantSeq[0];
        while (!stopped) begin
            @(negedge clk);
            cancelled = ABORT_EN && abortFired && (cyc > abortCyc);
            expBusy   = (cyc >= 1) && (cyc < expDone) && !cancelled;
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("busReq", 32'(bus_req), 32'(expBusy));
            checkOutput("done", 32'(done), 32'(cyc == expDone && !cancelled));
            checkOutput("frameCount", 32'(frame_count),
                        (cyc > expDone) ? 32'((expFrames + 1) % 256) : 32'(expFrames % 256));
            if (!bus_grant) checkOutput("noAccessWithoutGrant", 32'({bus_read, bus_write}), 32'd0);
            if (bus_write) begin
                expEntry = (expWr.size() != 0) ? expWr.pop_front() : 32'hDEADBEEF;
                lastWr   = {bus_address, bus_data_out};
                checkOutput("write", lastWr, expEntry);
            end
            if (bus_read) begin
                checkOutput("readAddress", 32'(bus_address), 32'(FB + 24'(rdIdx)));
                rdIdx++;
                if (abortTrig && !abortFired && bus_address == FB + 24'(2 * COLS + 10)) begin
                    abort      = 1'b1;
                    abortFired = 1'b1;
                    abortCyc   = cyc;
                end
                if (resetTrig && !resetFired && bus_address == FB + 24'(3 * COLS + 5)) begin
                    reset = 1'b1;
                    #1;
                    resetFired = 1'b1;
                    checkOutput("resetControl", 32'({bus_req, busy, bus_read, bus_write, done}), 32'd0);
                    checkOutput("resetAddress", 32'(bus_address), 32'd0);
                    checkOutput("resetData", 32'(bus_data_out), 32'd0);
                    checkOutput("resetFrameCount", 32'(frame_count), 32'd0);
                    stopped = 1'b1;
                end
            end
            if (done) begin
                doneCnt++;
                doneAt = cyc;
            end
            endCyc = (ABORT_EN && abortFired) ? abortCyc + 3 : expDone + 3;
            if (cyc >= endCyc) stopped = 1'b1;
            if (cyc >= MAXC - 2) begin
                checkOutput("timeout", 32'd1, 32'd0);
                stopped = 1'b1;
            end
            if (!stopped) begin
                @(posedge clk);
                #1;
                cyc++;
                start     = (cyc == midStart) || (startInFin && cyc == expDone);
                abort     = 1'b0;
                bus_grant = grantSeq[cyc];
            end
        end
        start = 1'b0;
        abort = 1'b0;

        if (resetTrig) begin
            checkOutput("resetFired", 32'(resetFired), 32'd1);
            expFrames = 0;
        end else if (ABORT_EN && abortFired) begin
            checkOutput("abortNoDone", 32'(doneCnt), 32'd0);
        end else begin
            checkOutput("doneCount", 32'(doneCnt), 32'd1);
            checkOutput("doneCycle", 32'(doneAt), 32'(expDone));
            checkOutput("writesRemaining", 32'(expWr.size()), 32'd0);
            checkOutput("readsSeen", 32'(rdIdx), 32'(FRAME));
            checkOutput("lastByte", lastWr, {DAT, ram[FRAME-1]});
            expFrames++;
        end
        if (abortTrig) checkOutput("abortFired", 32'(abortFired), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bus_grant = 1'b0;
        for (int i = 0; i < FRAME; i++) ram[i] = 8'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetControl", 32'({bus_req, busy, bus_read, bus_write, done}), 32'd0);
        checkOutput("resetAddress", 32'(bus_address), 32'd0);
        checkOutput("resetData", 32'(bus_data_out), 32'd0);
        checkOutput("resetFrameCount", 32'(frame_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] full grant, RAM[i]=i");
        applyStimulus(0, -1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < FRAME; i++) ram[i] = 8'($urandom);
        ram[FRAME-1] = 8'hA5;
        $display("[TB] grant toggling every other cycle");
        applyStimulus(1, -1, 1'b0, 1'b0, 1'b0);

        $display("[TB] random grant, start mid-copy and in FIN");
        applyStimulus(2, 500, 1'b1, 1'b0, 1'b0);

        $display("[TB] abort at page 2 col 10");
        applyStimulus(0, -1, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset during page 3 read, then restart");
        applyStimulus(0, -1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, -1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
